// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: grant state encoding
// and the hold-counter width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    // Width needed to count 0..max_hold inclusive.
    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux2.sv
// Two-input data-path multiplexer: y = sel ? b : a.
// Latency: combinational, zero cycles.
// Backpressure: none, pure data path.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing one valid/ready port between two requesters, with a hold limit.
// Latency: grant one cycle after request; out_valid/out_data combinational from registered grant.
// Backpressure: out_ready stalls the owner; a grant is never pulled from a pending, unaccepted beat.
module bus_arbiter2
    import arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int            CW   = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last;
    logic          sel_q;
    logic [CW-1:0] beat_cnt;
    logic          accept;
    logic          hold_hit;

    assign gnt0      = (state == G0);
    assign gnt1      = (state == G1);
    assign busy      = gnt0 | gnt1;
    assign sel       = sel_q;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign accept    = out_valid & out_ready;

    // The accepted beat in this cycle brings the count up to the limit.
    assign hold_hit  = accept && (beat_cnt >= (HOLD - CW'(1)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last))
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
            end
            G0: begin
                if (!req0 || (hold_hit && req1))
                    state_nxt = req1 ? G1 : IDLE;
            end
            G1: begin
                if (!req1 || (hold_hit && req0))
                    state_nxt = req0 ? G0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            sel_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                beat_cnt <= '0;
                // sel and last follow the new owner; both hold through IDLE.
                if (state_nxt == G0) begin
                    last  <= 1'b0;
                    sel_q <= 1'b0;
                end else if (state_nxt == G1) begin
                    last  <= 1'b1;
                    sel_q <= 1'b1;
                end
            end else if (accept && (beat_cnt < HOLD)) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    mux2 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .a   (d0),
        .b   (d1),
        .y   (out_data)
    );

endmodule
